router_in_port: RTL and testbench

Input port stage of the mesh router, directly upstream of the per-direction `fifo_arb` instances. It accepts one `t_tile_trans` per cycle from a neighbouring tile's link and buffers it in a small FIFO. It computes the XY route from the destination tile ID in the address, writes the result into `next_tile_fifo_arb_id`, and presents the transaction to exactly one of five destinations (N/E/S/W arbiters, or local) with a per-destination valid/ready handshake.

---
 rtl/router_pkg.sv | 47 ++++
 rtl/router_in_fifo.sv | 63 ++++++
 rtl/router_in_port.sv | 85 ++++++++
 tb/tb_router_in_port.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Package     : router_pkg
// Description : Shared router types, tile-ID field locations and XY routing.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    typedef enum logic [2:0] {
        NORTH = 3'd0,
        EAST  = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        LOCAL = 3'd4
    } t_cardinal;

    localparam int TILE_Y_MSB = 31;
    localparam int TILE_Y_LSB = 28;
    localparam int TILE_X_MSB = 27;
    localparam int TILE_X_LSB = 24;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  byte_en;
        logic        write;
        t_cardinal   next_tile_fifo_arb_id;
    } t_tile_trans;

    // Dimension-ordered routing: X is fully resolved before Y.
    function automatic t_cardinal xy_route(
        input logic [3:0] dx,
        input logic [3:0] dy,
        input logic [3:0] lx,
        input logic [3:0] ly
    );
        t_cardinal dir;
        if (dx > lx)      dir = EAST;
        else if (dx < lx) dir = WEST;
        else if (dy > ly) dir = NORTH;
        else if (dy < ly) dir = SOUTH;
        else              dir = LOCAL;
        return dir;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_in_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_in_fifo
// Description : Parameterised synchronous FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module router_in_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  T                             i_data,
    input  logic                         i_pop,
    output T                             o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage is deliberately left out of reset; only pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_in_port.sv
`default_nettype none
// ============================================================================
// Module      : router_in_port
// Description : Mesh router input port: link FIFO, XY route, registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module router_in_port
    import router_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [3:0] LOCAL_X = 4'd0,
    parameter logic [3:0] LOCAL_Y = 4'd0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  t_tile_trans                  in_req,
    output logic                         in_ready,
    output logic [4:0]                   out_valid,
    output t_tile_trans                  out_req,
    input  logic [4:0]                   out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    t_tile_trans  w_head;
    t_tile_trans  w_routed;
    t_cardinal    w_dir;
    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    logic         w_fire;

    logic         r_out_vld;
    t_cardinal    r_out_dir;
    t_tile_trans  r_out_req;

    assign in_ready = !w_full && !rst;
    assign w_push   = in_valid && in_ready;

    router_in_fifo #(
        .DEPTH (DEPTH),
        .T     (t_tile_trans)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (in_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (occupancy)
    );

    assign w_dir = xy_route(w_head.address[TILE_X_MSB:TILE_X_LSB],
                            w_head.address[TILE_Y_MSB:TILE_Y_LSB],
                            LOCAL_X, LOCAL_Y);

    always_comb begin
        w_routed                       = w_head;
        w_routed.next_tile_fifo_arb_id = w_dir;
    end

    // Masking with rst keeps a handshake from completing in the reset cycle.
    assign out_valid = (r_out_vld && !rst) ? (5'd1 << r_out_dir) : 5'd0;
    assign out_req   = r_out_req;
    assign w_fire    = |(out_valid & out_ready);
    assign w_pop     = !w_empty && (!r_out_vld || w_fire) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_out_dir <= NORTH;
            r_out_req <= '0;
        end else if (w_pop) begin
            r_out_vld <= 1'b1;
            r_out_dir <= w_dir;
            r_out_req <= w_routed;
        end else if (w_fire) begin
            r_out_vld <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_in_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_in_port
// Description : Directed self-checking bench for router_in_port (tile 1,1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_in_port;
    import router_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    t_tile_trans  in_req;
    logic         in_ready;
    logic [4:0]   out_valid;
    t_tile_trans  out_req;
    logic [4:0]   out_ready;
    logic [2:0]   occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    router_in_port #(
        .DEPTH   (4),
        .LOCAL_X (4'd1),
        .LOCAL_Y (4'd1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_req    (in_req),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_req   (out_req),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    function automatic t_tile_trans mk(input logic [3:0] dx, input logic [3:0] dy,
                                       input logic [31:0] data);
        t_tile_trans t;
        t = '0;
        t.address = {dy, dx, 24'h00_5A40};
        t.data    = data;
        t.byte_en = 4'hF;
        t.write   = 1'b1;
        t.next_tile_fifo_arb_id = SOUTH;
        return t;
    endfunction

    function automatic t_tile_trans routed(input t_tile_trans t, input t_cardinal d);
        t.next_tile_fifo_arb_id = d;
        return t;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_req = '0; out_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 00000", out_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        checks++; if (out_req !== '0) begin errors++; $display("FAIL reset_out_req got %h exp 0", out_req); end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_route();
        logic [3:0] dxs [5] = '{4'd2, 4'd0, 4'd1, 4'd1, 4'd1};
        logic [3:0] dys [5] = '{4'd1, 4'd1, 4'd2, 4'd0, 4'd1};
        logic [4:0] ohs [5] = '{5'b00010, 5'b01000, 5'b00001, 5'b00100, 5'b10000};
        t_cardinal  drs [5] = '{EAST, WEST, NORTH, SOUTH, LOCAL};
        t_tile_trans t;
        for (int i = 0; i < 5; i++) begin
            t = mk(dxs[i], dys[i], 32'hA000_0000 + i);
            @(posedge clk); #1; in_valid = 1'b1; in_req = t; out_ready = 5'h1F;
            @(negedge clk);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_accept[%0d] got %b exp 1", i, in_ready); end
            @(posedge clk); #1; in_valid = 1'b0;
            @(negedge clk);
            checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL route_early[%0d] got %b exp 00000", i, out_valid); end
            @(negedge clk);
            checks++; if (out_valid !== ohs[i]) begin errors++; $display("FAIL route_valid[%0d] got %b exp %b", i, out_valid, ohs[i]); end
            checks++; if (out_req !== routed(t, drs[i])) begin errors++; $display("FAIL route_req[%0d] got %h exp %h", i, out_req, routed(t, drs[i])); end
            @(negedge clk);
            checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL route_after_fire[%0d] got %b exp 00000", i, out_valid); end
        end
    endtask

    task automatic test_full();
        logic exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 5'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1; in_valid = 1'b1; in_req = mk(4'd2, 4'd1, k);
            @(negedge clk);
            checks++; if (in_ready !== exp_rdy[k]) begin errors++; $display("FAIL full_in_ready[%0d] got %b exp %b", k, in_ready, exp_rdy[k]); end
        end
        @(posedge clk); #1; in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occupancy[%0d] got %0d exp 4", j, occupancy); end
            checks++; if (out_valid !== 5'b00010) begin errors++; $display("FAIL full_out_valid[%0d] got %b exp 00010", j, out_valid); end
            checks++; if (out_req !== routed(mk(4'd2, 4'd1, 0), EAST)) begin errors++; $display("FAIL full_out_req[%0d] got %h", j, out_req); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready[%0d] got %b exp 0", j, in_ready); end
        end
    endtask

    task automatic test_drain();
        logic exp_rdy [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        @(posedge clk); #1; out_ready = 5'h1F;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 5'b00010) begin errors++; $display("FAIL drain_valid[%0d] got %b exp 00010", k, out_valid); end
            checks++; if (out_req !== routed(mk(4'd2, 4'd1, k), EAST)) begin errors++; $display("FAIL drain_req[%0d] got data %0d exp %0d", k, out_req.data, k); end
            checks++; if (in_ready !== exp_rdy[k]) begin errors++; $display("FAIL drain_in_ready[%0d] got %b exp %b", k, in_ready, exp_rdy[k]); end
        end
        @(negedge clk);
        checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL drain_empty_valid got %b exp 00000", out_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL drain_empty_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_hol();
        @(posedge clk); #1; out_ready = 5'b00001; in_valid = 1'b1; in_req = mk(4'd2, 4'd1, 10);
        @(posedge clk); #1; in_req = mk(4'd1, 4'd2, 11);
        @(posedge clk); #1; in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++; if (out_valid !== 5'b00010) begin errors++; $display("FAIL hol_blocked_valid[%0d] got %b exp 00010", j, out_valid); end
            checks++; if (out_req !== routed(mk(4'd2, 4'd1, 10), EAST)) begin errors++; $display("FAIL hol_blocked_req[%0d] got data %0d exp 10", j, out_req.data); end
            checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL hol_blocked_occ[%0d] got %0d exp 1", j, occupancy); end
        end
        @(posedge clk); #1; out_ready = 5'b00011;
        @(negedge clk);
        checks++; if (out_valid !== 5'b00010) begin errors++; $display("FAIL hol_east_valid got %b exp 00010", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 5'b00001) begin errors++; $display("FAIL hol_north_valid got %b exp 00001", out_valid); end
        checks++; if (out_req !== routed(mk(4'd1, 4'd2, 11), NORTH)) begin errors++; $display("FAIL hol_north_req got %h", out_req); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL hol_north_occ got %0d exp 0", occupancy); end
        @(negedge clk);
        checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL hol_done_valid got %b exp 00000", out_valid); end
    endtask

    task automatic test_reset_mid();
        t_tile_trans t;
        out_ready = 5'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1; in_valid = 1'b1; in_req = mk(4'd2, 4'd1, 20 + k);
        end
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL mid_pre_occ got %0d exp 2", occupancy); end
        checks++; if (out_valid !== 5'b00010) begin errors++; $display("FAIL mid_pre_valid got %b exp 00010", out_valid); end
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 00000", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", in_ready); end
        @(posedge clk); #1; rst = 1'b0; out_ready = 5'h1F;
        @(negedge clk);
        checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL mid_post_valid got %b exp 00000", out_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mid_post_occ got %0d exp 0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_post_ready got %b exp 1", in_ready); end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL mid_stale[%0d] got %b exp 00000", j, out_valid); end
        end
        t = mk(4'd1, 4'd2, 30);
        @(posedge clk); #1; in_valid = 1'b1; in_req = t;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL mid_fresh_early got %b exp 00000", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 5'b00001) begin errors++; $display("FAIL mid_fresh_valid got %b exp 00001", out_valid); end
        checks++; if (out_req !== routed(t, NORTH)) begin errors++; $display("FAIL mid_fresh_req got %h exp %h", out_req, routed(t, NORTH)); end
        @(negedge clk);
        checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL mid_fresh_done got %b exp 00000", out_valid); end
    endtask

    initial begin
        test_reset();
        test_route();
        test_full();
        test_drain();
        test_hol();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
